program_loader: RTL

PROGRAM_LOADER -- requirements
Module: program_loader

---
 rtl/program_loader_if.sv | 25 ++
 rtl/program_loader.sv | 197 +++++++++++++++++++
 2 files changed

// File: rtl/program_loader_if.sv
// Loader byte stream in, processor instruction/data memory write port out.
interface program_loader_if;
   logic [7:0]  byte_in;
   logic        byte_valid;
   logic        byte_ready;
   logic [31:0] instruction;
   logic [6:0]  instructionAddress;
   logic [31:0] data;
   logic [6:0]  dataAddress;
   logic        writeEnable;
   logic        done;
   logic [7:0]  err_count;

   modport master (
      output byte_in, byte_valid,
      input  byte_ready, instruction, instructionAddress, data, dataAddress,
             writeEnable, done, err_count
   );

   modport slave (
      input  byte_in, byte_valid,
      output byte_ready, instruction, instructionAddress, data, dataAddress,
             writeEnable, done, err_count
   );
endinterface

// File: rtl/program_loader.sv
// Receives 12-byte checksummed frames and commits one instruction word and one
// data word per frame to the processor memories through a timed write strobe.
//
// state  | meaning
// IDLE   | hunting for SYNC 0xA5 or end marker 0x5A
// IADDR  | receiving instruction address byte
// IWORD  | receiving instruction word, MSB first
// DADDR  | receiving data address byte
// DWORD  | receiving data word, MSB first
// CSUM   | checking XOR checksum and address range
// SETUP  | outputs updated, strobe held low for one cycle
// STROBE | writeEnable high for WE_CYCLES cycles
// DONE   | program loaded, terminal until rst
module program_loader #(
   parameter int unsigned WE_CYCLES = 2
) (
   input  logic             clk,
   input  logic             rst,
   program_loader_if.slave  bus
);

   typedef enum logic [3:0] {
      ST_IDLE,
      ST_IADDR,
      ST_IWORD,
      ST_DADDR,
      ST_DWORD,
      ST_CSUM,
      ST_SETUP,
      ST_STROBE,
      ST_DONE
   } state_t;

   localparam logic [7:0] SYNC_BYTE = 8'hA5;
   localparam logic [7:0] END_BYTE  = 8'h5A;
   localparam logic [3:0] WE_LOAD   = 4'(WE_CYCLES - 1);

   state_t      state_q,    state_d;
   logic [1:0]  cnt_q,      cnt_d;
   logic [3:0]  we_cnt_q,   we_cnt_d;
   logic [7:0]  csum_q,     csum_d;
   logic [7:0]  iaddr_sh_q, iaddr_sh_d;
   logic [31:0] iword_sh_q, iword_sh_d;
   logic [7:0]  daddr_sh_q, daddr_sh_d;
   logic [31:0] dword_sh_q, dword_sh_d;
   logic [31:0] instr_q,    instr_d;
   logic [6:0]  iaddr_q,    iaddr_d;
   logic [31:0] data_q,     data_d;
   logic [6:0]  daddr_q,    daddr_d;
   logic [7:0]  err_q,      err_d;

   logic        ready;
   logic        xfer;
   logic [7:0]  rx;

   assign ready = (state_q == ST_IDLE)  || (state_q == ST_IADDR) ||
                  (state_q == ST_IWORD) || (state_q == ST_DADDR) ||
                  (state_q == ST_DWORD) || (state_q == ST_CSUM);
   assign xfer  = bus.byte_valid && ready;
   assign rx    = bus.byte_in;

   always_comb begin
      state_d    = state_q;
      cnt_d      = cnt_q;
      we_cnt_d   = we_cnt_q;
      csum_d     = csum_q;
      iaddr_sh_d = iaddr_sh_q;
      iword_sh_d = iword_sh_q;
      daddr_sh_d = daddr_sh_q;
      dword_sh_d = dword_sh_q;
      instr_d    = instr_q;
      iaddr_d    = iaddr_q;
      data_d     = data_q;
      daddr_d    = daddr_q;
      err_d      = err_q;

      case (state_q)
         ST_IDLE: begin
            if (xfer) begin
               if (rx == SYNC_BYTE) begin
                  state_d = ST_IADDR;
                  csum_d  = 8'h00;
                  cnt_d   = 2'd0;
               end else if (rx == END_BYTE) begin
                  state_d = ST_DONE;
               end
            end
         end
         ST_IADDR: begin
            if (xfer) begin
               iaddr_sh_d = rx;
               csum_d     = csum_q ^ rx;
               cnt_d      = 2'd0;
               state_d    = ST_IWORD;
            end
         end
         ST_IWORD: begin
            if (xfer) begin
               iword_sh_d = {iword_sh_q[23:0], rx};
               csum_d     = csum_q ^ rx;
               cnt_d      = cnt_q + 2'd1;
               if (cnt_q == 2'd3) state_d = ST_DADDR;
            end
         end
         ST_DADDR: begin
            if (xfer) begin
               daddr_sh_d = rx;
               csum_d     = csum_q ^ rx;
               cnt_d      = 2'd0;
               state_d    = ST_DWORD;
            end
         end
         ST_DWORD: begin
            if (xfer) begin
               dword_sh_d = {dword_sh_q[23:0], rx};
               csum_d     = csum_q ^ rx;
               cnt_d      = cnt_q + 2'd1;
               if (cnt_q == 2'd3) state_d = ST_CSUM;
            end
         end
         ST_CSUM: begin
            // Outputs are loaded on entry to SETUP so they settle a full cycle before the strobe.
            if (xfer) begin
               if ((rx == csum_q) && !iaddr_sh_q[7] && !daddr_sh_q[7]) begin
                  instr_d  = iword_sh_q;
                  iaddr_d  = iaddr_sh_q[6:0];
                  data_d   = dword_sh_q;
                  daddr_d  = daddr_sh_q[6:0];
                  state_d  = ST_SETUP;
               end else begin
                  if (err_q != 8'hFF) err_d = err_q + 8'd1;
                  state_d = ST_IDLE;
               end
            end
         end
         ST_SETUP: begin
            we_cnt_d = WE_LOAD;
            state_d  = ST_STROBE;
         end
         ST_STROBE: begin
            if (we_cnt_q == 4'd0) begin
               state_d = ST_IDLE;
            end else begin
               we_cnt_d = we_cnt_q - 4'd1;
            end
         end
         ST_DONE: begin
            state_d = ST_DONE;
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q    <= ST_IDLE;
         cnt_q      <= 2'd0;
         we_cnt_q   <= 4'd0;
         csum_q     <= 8'h00;
         iaddr_sh_q <= 8'h00;
         iword_sh_q <= 32'h0;
         daddr_sh_q <= 8'h00;
         dword_sh_q <= 32'h0;
         instr_q    <= 32'h0;
         iaddr_q    <= 7'h0;
         data_q     <= 32'h0;
         daddr_q    <= 7'h0;
         err_q      <= 8'h00;
      end else begin
         state_q    <= state_d;
         cnt_q      <= cnt_d;
         we_cnt_q   <= we_cnt_d;
         csum_q     <= csum_d;
         iaddr_sh_q <= iaddr_sh_d;
         iword_sh_q <= iword_sh_d;
         daddr_sh_q <= daddr_sh_d;
         dword_sh_q <= dword_sh_d;
         instr_q    <= instr_d;
         iaddr_q    <= iaddr_d;
         data_q     <= data_d;
         daddr_q    <= daddr_d;
         err_q      <= err_d;
      end
   end

   assign bus.byte_ready         = ready;
   assign bus.instruction        = instr_q;
   assign bus.instructionAddress = iaddr_q;
   assign bus.data               = data_q;
   assign bus.dataAddress        = daddr_q;
   assign bus.writeEnable        = (state_q == ST_STROBE);
   assign bus.done               = (state_q == ST_DONE);
   assign bus.err_count          = err_q;

endmodule
